// File: rtl/fcs_append_ctrl_if.sv
// Stream, CRC-engine and status signals of the FCS append sequencer.
// slave: the sequencer itself; master: the surrounding environment.
interface fcs_append_ctrl_if #(
    parameter int unsigned CNT_W = 12
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             abort;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic             crc_rst;
    logic             crc_en;
    logic [3:0]       crc_nibble;
    logic [31:0]      crc_value;
    logic [CNT_W-1:0] byte_count;
    logic             busy;
    logic             fcs_done;

    modport slave (
        input  in_data, in_valid, in_last, abort, out_ready, crc_value,
        output in_ready, out_data, out_valid, out_last, crc_rst, crc_en, crc_nibble,
               byte_count, busy, fcs_done
    );

    modport master (
        output in_data, in_valid, in_last, abort, out_ready, crc_value,
        input  in_ready, out_data, out_valid, out_last, crc_rst, crc_en, crc_nibble,
               byte_count, busy, fcs_done
    );
endinterface

// File: rtl/fcs_append_ctrl.sv
// Transmit FCS sequencer: feeds each MPDU byte (low nibble first) to the external
// nibble-serial CRC-32 engine, forwards the byte, then appends the 4-byte FCS LSB first.
module fcs_append_ctrl #(
    parameter bit          FCS_INVERT = 1'b0,
    parameter int unsigned CNT_W      = 12
) (
    input logic                clk,
    input logic                rst,
    fcs_append_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {StIdle, StLo, StHi, StOut, StFcs, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0]       byte_q;
    logic             last_q;
    logic [1:0]       idx_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      fcs;
    logic [31:0]      fcs_shift;

    // The engine is idle throughout StFcs, so crc_value is stable while emitting.
    assign fcs       = FCS_INVERT ? ~bus.crc_value : bus.crc_value;
    assign fcs_shift = fcs >> {idx_q, 3'b000};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.in_valid) state_d = StLo;
                StLo:    state_d = StHi;
                StHi:    state_d = StOut;
                StOut:   if (bus.out_ready) state_d = last_q ? StFcs : StIdle;
                StFcs:   if (bus.out_ready && idx_q == 2'd3) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Byte capture, FCS byte index, frame counter and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q <= 8'h00;
            last_q <= 1'b0;
            idx_q  <= 2'd0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (bus.abort) begin
            idx_q  <= 2'd0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        byte_q <= bus.in_data;
                        last_q <= bus.in_last;
                        busy_q <= 1'b1;
                        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StOut:  idx_q <= 2'd0;
                StFcs:  if (bus.out_ready) idx_q <= idx_q + 2'd1;
                StDone: begin
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_last   = 1'b0;
        bus.out_data   = 8'h00;
        bus.crc_en     = 1'b0;
        bus.crc_nibble = 4'h0;
        bus.crc_rst    = 1'b0;
        bus.fcs_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                // Between bytes of a frame the engine must keep accumulating.
                bus.crc_rst  = !busy_q;
            end
            StLo: begin
                bus.crc_en     = 1'b1;
                bus.crc_nibble = byte_q[3:0];
            end
            StHi: begin
                bus.crc_en     = 1'b1;
                bus.crc_nibble = byte_q[7:4];
            end
            StOut: begin
                bus.out_valid = 1'b1;
                bus.out_data  = byte_q;
            end
            StFcs: begin
                bus.out_valid = 1'b1;
                bus.out_data  = fcs_shift[7:0];
                bus.out_last  = (idx_q == 2'd3);
            end
            StDone:  bus.fcs_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.byte_count = cnt_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_fcs_append_ctrl.sv
// Bench for fcs_append_ctrl: table of frames with known CRC-32 check values, a
// behavioural nibble CRC engine, a scoreboard queue of expected output bytes and
// hand-written abort / reset sequences.
module tb_fcs_append_ctrl;
    typedef struct {
        int          len;
        logic [7:0]  data [16];
        bit          stall;
        logic [31:0] fcs;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] crc_reg;
    bit   stall_mode = 1'b0;

    int checks = 0;
    int errors = 0;
    int crc_en_cnt, done_cnt, overlap_cnt, busy_rst_cnt, stall_viol;
    logic [11:0] done_byte_count;
    exp_t sb[$];
    vec_t vecs[5];

    fcs_append_ctrl_if #(.CNT_W(12)) ifc ();

    fcs_append_ctrl #(
        .FCS_INVERT(1'b0),
        .CNT_W     (12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] nib_step(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] r;
        r = c ^ {28'h0, n};
        for (int b = 0; b < 4; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Reflected CRC-32 engine, nibble serial, final complement built in.
    always @(posedge clk or posedge rst) begin
        if (rst)              crc_reg <= 32'hFFFFFFFF;
        else if (ifc.crc_rst) crc_reg <= 32'hFFFFFFFF;
        else if (ifc.crc_en)  crc_reg <= nib_step(crc_reg, ifc.crc_nibble);
    end
    assign ifc.crc_value = ~crc_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor sampled on the falling edge: counters and scoreboard pops.
    initial begin
        exp_t e;
        bit   stalled_prev = 1'b0;
        logic [7:0] prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifc.crc_en) crc_en_cnt++;
                if (ifc.crc_en && ifc.crc_rst) overlap_cnt++;
                if (ifc.busy && ifc.crc_rst) busy_rst_cnt++;
                if (ifc.fcs_done) begin
                    done_cnt++;
                    done_byte_count = ifc.byte_count;
                end
                if (stalled_prev && ifc.out_valid && ifc.out_data != prev_data) stall_viol++;
                stalled_prev = ifc.out_valid && !ifc.out_ready && !ifc.abort;
                prev_data    = ifc.out_data;
                if (ifc.out_valid && ifc.out_ready && !ifc.abort) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", {24'h0, ifc.out_data}, 32'hFFFFFFFF);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", {24'h0, ifc.out_data}, {24'h0, e.data});
                        check("out_last", {31'h0, ifc.out_last}, {31'h0, e.last});
                    end
                end
            end
        end
    end

    // Downstream ready: constant or toggling every cycle.
    initial begin
        ifc.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ifc.out_ready = stall_mode ? ~ifc.out_ready : 1'b1;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        ifc.in_last  = last;
        @(negedge clk);
        while (!ifc.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic clear_counters();
        crc_en_cnt   = 0;
        done_cnt     = 0;
        overlap_cnt  = 0;
        busy_rst_cnt = 0;
        stall_viol   = 0;
        done_byte_count = 12'hFFF;
    endtask

    task automatic run_vec(input int k);
        int n = 0;
        stall_mode = vecs[k].stall;
        clear_counters();
        for (int i = 0; i < vecs[k].len; i++) begin
            sb.push_back('{data: vecs[k].data[i], last: 1'b0});
            send_byte(vecs[k].data[i], i == vecs[k].len - 1);
        end
        for (int b = 0; b < 4; b++) sb.push_back('{data: vecs[k].fcs[8*b +: 8], last: b == 3});
        while (!ifc.fcs_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("fcs_done_timeout", 32'h0, 32'h1);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("fcs_done_pulses", done_cnt, 1);
        check("crc_en_cycles", crc_en_cnt, 2 * vecs[k].len);
        check("byte_count_at_done", {20'h0, done_byte_count}, vecs[k].len);
        check("crc_en_rst_overlap", overlap_cnt, 0);
        check("crc_rst_while_busy", busy_rst_cnt, 0);
        check("stall_stability", stall_viol, 0);
        check("crc_rst_after_frame", {31'h0, ifc.crc_rst}, 32'h1);
        check("busy_after_frame", {31'h0, ifc.busy}, 32'h0);
        sb.delete();
        stall_mode = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        ifc.in_last  = 1'b0;
        ifc.abort    = 1'b0;

        for (int i = 0; i < 9; i++) vecs[0].data[i] = 8'h31 + 8'(i);
        vecs[0].len = 9;  vecs[0].stall = 1'b0;  vecs[0].fcs = 32'hCBF43926;
        vecs[1] = vecs[0];
        vecs[1].stall = 1'b1;
        vecs[2].len = 1;  vecs[2].data[0] = 8'h00;  vecs[2].stall = 1'b0;
        vecs[2].fcs = 32'hD202EF8D;
        vecs[3].len = 1;  vecs[3].data[0] = 8'h61;  vecs[3].stall = 1'b0;
        vecs[3].fcs = 32'hE8B7BE43;
        vecs[4] = vecs[0];

        // Reset values.
        #1;
        check("rst_in_ready", {31'h0, ifc.in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        check("rst_crc_rst", {31'h0, ifc.crc_rst}, 32'h1);
        check("rst_crc_en", {31'h0, ifc.crc_en}, 32'h0);
        check("rst_byte_count", {20'h0, ifc.byte_count}, 32'h0);
        check("rst_busy", {31'h0, ifc.busy}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: plain, stalled, single zero byte, then "a" and "123456789" back to back.
        for (int k = 0; k < 5; k++) run_vec(k);

        // Abort while FCS byte 2 is presented.
        clear_counters();
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{data: vecs[0].data[i], last: 1'b0});
            send_byte(vecs[0].data[i], i == 8);
        end
        for (int b = 0; b < 4; b++) sb.push_back('{data: vecs[0].fcs[8*b +: 8], last: b == 3});
        n = 0;
        while (sb.size() != 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("abort_point_timeout", 32'h0, 32'h1);
        ifc.abort = 1'b1;
        @(posedge clk);
        #1;
        ifc.abort = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        check("abort_busy", {31'h0, ifc.busy}, 32'h0);
        check("abort_byte_count", {20'h0, ifc.byte_count}, 32'h0);
        check("abort_crc_rst", {31'h0, ifc.crc_rst}, 32'h1);
        repeat (3) @(negedge clk);
        check("abort_no_fcs_done", done_cnt, 0);
        @(posedge clk);
        #1;
        run_vec(0);

        // abort and in_valid together in idle: byte is dropped.
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h55;
        ifc.abort    = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.abort    = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", {31'h0, ifc.busy}, 32'h0);
        check("abort_idle_count", {20'h0, ifc.byte_count}, 32'h0);
        check("abort_idle_crc_en", {31'h0, ifc.crc_en}, 32'h0);
        @(posedge clk);
        #1;

        // Asynchronous reset pulsed between edges while in the low-nibble state.
        send_byte(8'h31, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready", {31'h0, ifc.in_ready}, 32'h1);
        check("arst_crc_en", {31'h0, ifc.crc_en}, 32'h0);
        check("arst_crc_rst", {31'h0, ifc.crc_rst}, 32'h1);
        check("arst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        check("arst_busy", {31'h0, ifc.busy}, 32'h0);
        check("arst_byte_count", {20'h0, ifc.byte_count}, 32'h0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fcs_append_ctrl.md
Name: fcs_append_ctrl

Overview:
Transmit-side frame check sequence sequencer for the OFDM TX chain. Accepts MPDU bytes over a valid/ready stream and feeds each byte, low nibble first, to the external nibble-serial CRC-32 engine. Forwards every byte downstream, then appends the 4-byte FCS, LSB first. It also owns the engine's per-frame clear, so the engine needs no other control.

Parameters:
FCS_INVERT, 0, 1 = XOR engine result with 0xFFFFFFFF before emission; 0 = engine value is the final FCS
CNT_W, 12, width of byte_count (max frame 4095 bytes)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
in_data  in  8  MPDU byte
in_valid  in  1  in_data valid
in_last  in  1  marks final MPDU byte (qualified by in_valid)
in_ready  out  1  block can accept a byte
abort  in  1  drop current frame, return to idle
out_data  out  8  payload byte or FCS byte
out_valid  out  1  out_data valid
out_last  out  1  final FCS byte
out_ready  in  1  downstream accepts out_data
crc_rst  out  1  synchronous clear to CRC engine
crc_en  out  1  CRC engine nibble strobe
crc_nibble  out  4  nibble to CRC engine
crc_value  in  32  CRC engine accumulator (registered, updates cycle after crc_en)
byte_count  out  CNT_W  payload bytes accepted in current frame
busy  out  1  frame in progress
fcs_done  out  1  one-cycle pulse after last FCS byte handshake

Behaviour:
- Reset (async): state=IDLE. Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, crc_en=0, crc_nibble=0, crc_rst=1, byte_count=0, busy=0, fcs_done=0.
- States:
  - IDLE: in_ready=1. crc_rst=1 while busy=0.
    - On in_valid: capture in_data/in_last into byte_r/last_r, set busy, byte_count+=1 (saturating at all-ones), go to LO.
  - LO: crc_en=1, crc_nibble=byte_r[3:0]; go to HI.
  - HI: crc_en=1, crc_nibble=byte_r[7:4]; go to OUT.
  - OUT: out_valid=1, out_data=byte_r.
    - On out_ready with last_r=1: go to FCS with idx=0.
    - On out_ready with last_r=0: go to IDLE (busy stays 1, no crc_rst).
  - FCS: out_valid=1, out_data=fcs[8*idx+7:8*idx], where fcs = crc_value, or ~crc_value when FCS_INVERT=1. out_last=(idx==3).
    - On out_ready: idx+=1.
    - Handshake at idx==3: go to DONE.
  - DONE: fcs_done=1 for one cycle, busy<=0, byte_count<=0, go to IDLE. crc_rst asserts from the next cycle.
- crc_en and crc_rst are never high in the same cycle. crc_en is high only in LO/HI.
- Latency: byte accepted at cycle t; crc_en at t+1 and t+2; out_valid from t+3. Peak throughput is 1 byte per 4 cycles.
- out_data and out_valid are held stable while out_valid=1 and out_ready=0. The FCS is sampled from crc_value, which is stable because no crc_en occurs in FCS.
- in_ready is high only in IDLE. in_valid in other states is ignored; upstream holds it.
- abort, sampled in any state (takes priority over all transitions): go to IDLE next cycle.
  - out_valid=0, busy=0, byte_count=0; crc_rst=1 from the next cycle. No fcs_done.
  - abort and in_valid in the same IDLE cycle: abort wins, byte not accepted.
- A 1-byte frame (in_last on first byte) is legal: 1 payload byte + 4 FCS bytes.
- rst asserted mid-frame: immediate return to reset values. Any partial output is discarded by downstream via its own reset.

Test Plan:
- ASCII "123456789" (0x31..0x39, last on 0x39), out_ready=1, FCS_INVERT=0, with the team nibble CRC engine -> out bytes 31..39 then 26 39 F4 CB; out_last only on CB; fcs_done one pulse; byte_count=9 before DONE.
- Same frame with out_ready toggled 1/0 every cycle -> identical byte sequence; out_data stable while stalled; no extra crc_en pulses (18 total).
- Single byte 0x00 with last -> 5 output bytes; crc_en high exactly 2 cycles; crc_rst low from accept through DONE, high afterwards.
- abort asserted during FCS idx=2 -> out_valid drops next cycle, no fcs_done, busy=0; next frame "123456789" yields 26 39 F4 CB (engine properly cleared).
- Back-to-back frames "a" then "123456789" -> crc_rst high at least one cycle between frames; second FCS matches the first test.
- Async rst pulsed between clock edges mid-LO -> outputs at reset values immediately; crc_en=0; in_ready=1.
